// File: rtl/lcd1602_bus_monitor.sv
// lcd1602_bus_monitor: HD44780/LCD1602 bus receiver keeping a 2x16 shadow DDRAM.
// Define LCD_MON_READ_EN to answer bus reads on lcd_rd_data; without it reads only raise err_read.
module lcd1602_bus_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CLEAR_CELLS = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         lcd_en,
   input  logic         lcd_rs,
   input  logic         lcd_rw,
   input  logic [7:0]   lcd_data,
   output logic [127:0] row_1,
   output logic [127:0] row_2,
   output logic [6:0]   ddram_addr,
   output logic         disp_on,
   output logic         two_line,
   output logic         busy,
   output logic         xfer_strobe,
   output logic         xfer_rs,
   output logic [7:0]   xfer_byte,
   output logic         err_overrun,
   output logic         err_addr,
`ifdef LCD_MON_READ_EN
   output logic [7:0]   lcd_rd_data,
`endif
   output logic         err_read
);
   localparam int CW = $clog2(CLEAR_CELLS + 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state;
   logic [10:0]   sync_q [SYNC_STAGES];
   logic          en_prev;
   logic          en_s, rs_s, rw_s, fall;
   logic [7:0]    data_s;
   logic [7:0]    cells [32];
   logic          inc;
   logic [CW-1:0] clr_cnt;
   logic          vis;
   logic [4:0]    idx;

   assign en_s   = sync_q[SYNC_STAGES-1][10];
   assign rs_s   = sync_q[SYNC_STAGES-1][9];
   assign rw_s   = sync_q[SYNC_STAGES-1][8];
   assign data_s = sync_q[SYNC_STAGES-1][7:0];
   assign fall   = en_prev & ~en_s;
   assign vis    = ddram_addr[5:4] == 2'b00;
   assign idx    = {ddram_addr[6], ddram_addr[3:0]};

   for (genvar i = 0; i < 16; i++) begin : g_row
      assign row_1[127-8*i -: 8] = cells[i];
      assign row_2[127-8*i -: 8] = cells[16+i];
   end

   // HD44780 address counter step, wrapping between the two 40-cell lines.
   function automatic logic [6:0] ac_next(input logic [6:0] a, input logic up);
      return up ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
                : (a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1);
   endfunction

   // Bus synchronizer; the last stage feeds both the edge detector and the sampled fields.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         en_prev <= 1'b0;
      end else begin
         sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         en_prev <= en_s;
      end
   end

   // Transfer decoder and clear sequencer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         for (int c = 0; c < 32; c++) cells[c] <= 8'h20;
         ddram_addr  <= '0;
         inc         <= 1'b1;
         disp_on     <= 1'b0;
         two_line    <= 1'b0;
         busy        <= 1'b0;
         xfer_strobe <= 1'b0;
         xfer_rs     <= 1'b0;
         xfer_byte   <= '0;
         err_overrun <= 1'b0;
         err_addr    <= 1'b0;
         err_read    <= 1'b0;
         clr_cnt     <= '0;
      end else begin
         xfer_strobe <= 1'b0;
         if (state == IDLE) begin
            if (fall) begin
               if (rw_s) begin
`ifdef LCD_MON_READ_EN
                  if (rs_s) ddram_addr <= ac_next(ddram_addr, inc);
`else
                  err_read <= 1'b1;
`endif
               end else begin
                  xfer_strobe <= 1'b1;
                  xfer_rs     <= rs_s;
                  xfer_byte   <= data_s;
                  if (rs_s) begin
                     if (vis) cells[idx] <= data_s;
                     ddram_addr <= ac_next(ddram_addr, inc);
                  end else begin
                     casez (data_s)
                        8'b1???????: begin
                           ddram_addr <= data_s[6:0];
                           if (data_s[5:0] > 6'h27) err_addr <= 1'b1;
                        end
                        8'b001?????: two_line   <= data_s[3];
                        8'b00001???: disp_on    <= data_s[2];
                        8'b000001??: inc        <= data_s[1];
                        8'b0000001?: ddram_addr <= '0;
                        8'b00000001: begin
                           state   <= CLEAR;
                           busy    <= 1'b1;
                           clr_cnt <= '0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
         end else begin
            if (fall) err_overrun <= 1'b1;
            if (int'(clr_cnt) < 32) cells[5'(clr_cnt)] <= 8'h20;
            if (clr_cnt == CW'(CLEAR_CELLS - 1)) begin
               state      <= IDLE;
               busy       <= 1'b0;
               ddram_addr <= '0;
               inc        <= 1'b1;
            end else begin
               clr_cnt <= clr_cnt + CW'(1);
            end
         end
      end
   end

`ifdef LCD_MON_READ_EN
   // Read data is driven only while the host holds a read strobe.
   always_comb
      lcd_rd_data = !(en_s && rw_s) ? 8'h00 : !rs_s ? {busy, ddram_addr} : vis ? cells[idx] : 8'h20;
`endif
endmodule

// File: tb/tb_lcd1602_bus_monitor.sv
// tb_lcd1602_bus_monitor: random LCD1602 bus traffic checked against a behavioural DDRAM model.
module tb_lcd1602_bus_monitor;
   logic         clk = 1'b0, rst = 1'b0;
   logic         lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
   logic [7:0]   lcd_data = 8'h00;
   logic [127:0] row_1, row_2;
   logic [6:0]   ddram_addr;
   logic         disp_on, two_line, busy, xfer_strobe, xfer_rs;
   logic [7:0]   xfer_byte;
   logic         err_overrun, err_addr, err_read;
`ifdef LCD_MON_READ_EN
   logic [7:0]   lcd_rd_data;
`endif

   int n_checks = 0, n_pass = 0;
   int strobe_cnt = 0, busy_cnt = 0;

   logic [7:0] m1 [16];
   logic [7:0] m2 [16];
   int         m_ac, m_strobes;
   bit         m_inc, m_disp, m_two, m_ovr, m_aerr, m_rerr, m_xrs;
   logic [7:0] m_xb;

   lcd1602_bus_monitor dut (
      .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
      .row_1(row_1), .row_2(row_2), .ddram_addr(ddram_addr), .disp_on(disp_on), .two_line(two_line),
      .busy(busy), .xfer_strobe(xfer_strobe), .xfer_rs(xfer_rs), .xfer_byte(xfer_byte),
      .err_overrun(err_overrun), .err_addr(err_addr),
`ifdef LCD_MON_READ_EN
      .lcd_rd_data(lcd_rd_data),
`endif
      .err_read(err_read)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (xfer_strobe) strobe_cnt <= strobe_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic int adv(input int a, input bit up);
      if (up) return a == 39 ? 64 : a == 103 ? 0 : (a + 1) % 128;
      return a == 0 ? 103 : a == 64 ? 39 : (a + 127) % 128;
   endfunction

   function automatic logic [127:0] pack(input logic [7:0] r [16]);
      logic [127:0] v = '0;
      for (int i = 0; i < 16; i++) v = {v[119:0], r[i]};
      return v;
   endfunction

   task automatic m_clear;
      for (int i = 0; i < 16; i++) begin
         m1[i] = 8'h20;
         m2[i] = 8'h20;
      end
      m_ac  = 0;
      m_inc = 1;
   endtask

   task automatic m_reset;
      m_clear();
      m_disp = 0; m_two = 0; m_ovr = 0; m_aerr = 0; m_rerr = 0; m_xrs = 0; m_xb = 8'h00;
   endtask

   task automatic m_xfer(input bit rs, input bit rw, input logic [7:0] b);
      if (rw) begin
`ifdef LCD_MON_READ_EN
         if (rs) m_ac = adv(m_ac, m_inc);
`else
         m_rerr = 1;
`endif
         return;
      end
      m_strobes++;
      m_xrs = rs;
      m_xb  = b;
      if (rs) begin
         if (m_ac < 16) m1[m_ac] = b;
         else if (m_ac >= 64 && m_ac < 80) m2[m_ac-64] = b;
         m_ac = adv(m_ac, m_inc);
      end else if (b >= 128) begin
         m_ac = int'(b) - 128;
         if (m_ac % 64 > 39) m_aerr = 1;
      end
      else if (b >= 64) ;
      else if (b >= 32) m_two = b[3];
      else if (b >= 16) ;
      else if (b >= 8) m_disp = b[2];
      else if (b >= 4) m_inc = b[1];
      else if (b >= 2) m_ac = 0;
      else if (b == 1) m_clear();
   endtask

   task automatic check_all(input string tag);
      check({tag, ".row_1"}, row_1, pack(m1));
      check({tag, ".row_2"}, row_2, pack(m2));
      check({tag, ".ac"}, 128'(ddram_addr), 128'(m_ac));
      check({tag, ".flags"}, 128'({disp_on, two_line, busy, err_overrun, err_addr, err_read}),
            128'({m_disp, m_two, 1'b0, m_ovr, m_aerr, m_rerr}));
      check({tag, ".xfer"}, 128'({xfer_rs, xfer_byte}), 128'({m_xrs, m_xb}));
      check({tag, ".strobes"}, 128'(strobe_cnt), 128'(m_strobes));
   endtask

   // One bus cycle; lat is the clk count from en falling to xfer_strobe (0 if none).
   task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] b, input bit drop, output int lat);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data = b;
      @(negedge clk);
      lcd_en = 1'b1;
      repeat (2) @(negedge clk);
      lcd_en = 1'b0;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (xfer_strobe && lat == 0) lat = k;
      end
      if (drop) m_ovr = 1;
      else m_xfer(rs, rw, b);
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_timeout", 128'(busy), 128'(0));
   endtask

   initial begin
      int lat, r, b0;
      bit rs, rw;
      logic [7:0] b;
      logic [127:0] t1, t2;
      m_strobes = 0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      bus_xfer(0, 0, 8'h38, 0, lat);
      check("latency", 128'(lat), 128'(3));
      bus_xfer(0, 0, 8'h08, 0, lat);
      b0 = busy_cnt;
      bus_xfer(0, 0, 8'h01, 0, lat);
      wait_idle();
      check("busy_len", 128'(busy_cnt - b0), 128'(32));
      bus_xfer(0, 0, 8'h06, 0, lat);
      bus_xfer(0, 0, 8'h0C, 0, lat);
      check("init_strobes", 128'(strobe_cnt), 128'(5));
      check_all("init");

      bus_xfer(0, 0, 8'h80, 0, lat);
      bus_xfer(1, 0, "W", 0, lat);
      bus_xfer(1, 0, "A", 0, lat);
      bus_xfer(1, 0, "I", 0, lat);
      bus_xfer(1, 0, "T", 0, lat);
      check("wait_text", 128'(row_1[127:96]), 128'(32'h57414954));
      check_all("wait");

      bus_xfer(0, 0, 8'hA7, 0, lat);
      bus_xfer(1, 0, "A", 0, lat);
      bus_xfer(1, 0, "B", 0, lat);
      check("wrap_row2", 128'(row_2[127:120]), 128'(8'h42));
      check("wrap_ac", 128'(ddram_addr), 128'(7'h41));
      check_all("wrap");

      bus_xfer(0, 0, 8'h04, 0, lat);
      bus_xfer(0, 0, 8'h80, 0, lat);
      bus_xfer(1, 0, "X", 0, lat);
      check("dec_row1", 128'(row_1[127:120]), 128'(8'h58));
      check("dec_ac", 128'(ddram_addr), 128'(7'h67));
      check_all("dec");

      for (int t = 0; t < 80; t++) begin
         r = int'($urandom_range(0, 99));
         rs = 0;
         rw = 0;
         if (r < 40) begin
            rs = 1;
            b = 8'($urandom_range(32, 126));
         end else if (r < 55) b = 8'h80 | ($urandom_range(0, 1) != 0 ? 8'h40 : 8'h00) | 8'($urandom_range(0, 15));
         else if (r < 65) b = {1'b1, 7'($urandom)};
         else if (r < 75) b = 8'h04 | 8'($urandom_range(0, 3));
         else if (r < 92) begin
            b = 8'($urandom_range(0, 127));
            if (b == 8'h01) b = 8'h02;
         end else if (r < 96) begin
            rw = 1;
            rs = $urandom_range(0, 1) != 0;
            b = 8'($urandom);
         end else b = 8'h01;
         bus_xfer(rs, rw, b, 0, lat);
         if (!rs && !rw && b == 8'h01) wait_idle();
         check_all("rand");
      end

      bus_xfer(0, 0, 8'h01, 0, lat);
      b0 = strobe_cnt;
      bus_xfer(1, 0, "Z", 1, lat);
      check("overrun_nostrobe", 128'(strobe_cnt - b0), 128'(0));
      wait_idle();
      check_all("overrun");

      bus_xfer(1, 0, "Q", 0, lat);
      bus_xfer(0, 0, 8'hC0, 0, lat);
      bus_xfer(1, 0, "R", 0, lat);
      bus_xfer(0, 0, 8'h01, 0, lat);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      m_reset();
      check("rst_busy", 128'(busy), 128'(0));
      check_all("midclear_rst");
      @(negedge clk);
      rst = 1'b1;

      t1 = "LCD1602 LOOPBACK";
      t2 = "       SUS      ";
      bus_xfer(0, 0, 8'h38, 0, lat);
      bus_xfer(0, 0, 8'h0C, 0, lat);
      bus_xfer(0, 0, 8'h06, 0, lat);
      bus_xfer(0, 0, 8'h01, 0, lat);
      wait_idle();
      bus_xfer(0, 0, 8'h80, 0, lat);
      for (int i = 0; i < 16; i++) bus_xfer(1, 0, t1[127-8*i -: 8], 0, lat);
      bus_xfer(0, 0, 8'hC0, 0, lat);
      for (int i = 0; i < 16; i++) bus_xfer(1, 0, t2[127-8*i -: 8], 0, lat);
      check("drv_row1", row_1, t1);
      check("drv_row2", row_2, t2);
      check_all("driver");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
